// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data and debug requesters (dm > if > dbg).
// Optional wait-cycle counters are enabled with `define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [3:0]      dm_be_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,
    input  logic            dbg_req_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]     perf_if_wait_o,
    output logic [31:0]     perf_dm_wait_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_DBG} own_t;

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [2:0]      LAT_INIT   = 3'(MEM_LATENCY - 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    state_t          r_state;
    own_t            r_owner;
    logic            r_store;
    logic [2:0]      r_cnt;
    logic [SW-1:0]   r_starve;
    logic            r_if_rvalid;
    logic            r_dm_rvalid;
    logic            r_dbg_rvalid;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_dm_rdata;
    logic [XLEN-1:0] r_dbg_rdata;

    logic w_arb;
    logic w_pri;
    logic w_dm_win;
    logic w_if_win;
    logic w_dbg_win;
    logic w_any;
    logic w_unused;

    // Arbitration is open whenever the port is not waiting on memory.
    assign w_arb     = (r_state != S_WAIT);
    assign w_pri     = dbg_req_i & (r_starve >= STARVE_LIM);
    assign w_dm_win  = w_arb & dm_req_i & ~w_pri;
    assign w_if_win  = w_arb & if_req_i & ~dm_req_i & ~w_pri;
    assign w_dbg_win = w_arb & dbg_req_i & (w_pri | (~dm_req_i & ~if_req_i));
    assign w_any     = w_dm_win | w_if_win | w_dbg_win;

    assign if_gnt_o  = w_if_win;
    assign dm_gnt_o  = w_dm_win;
    assign dbg_gnt_o = w_dbg_win;
    assign busy_o    = (r_state != S_IDLE);

    assign if_rvalid_o  = r_if_rvalid;
    assign dm_rvalid_o  = r_dm_rvalid;
    assign dbg_rvalid_o = r_dbg_rvalid;
    assign if_rdata_o   = r_if_rdata;
    assign dm_rdata_o   = r_dm_rdata;
    assign dbg_rdata_o  = r_dbg_rdata;

    assign w_unused = &{1'b0, if_addr_i[1:0], dbg_addr_i[1:0]};

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (1'b1)
            w_dm_win: begin
                mem_req_o = 1'b1;
                if (dm_we_i) begin
                    mem_we_o    = 1'b1;
                    mem_be_o    = dm_be_i;
                    mem_addr_o  = dm_addr_i;
                    mem_wdata_o = dm_wdata_i;
                end else begin
                    mem_be_o   = 4'hF;
                    mem_addr_o = {dm_addr_i[XLEN-1:2], 2'b00};
                end
            end
            w_if_win: begin
                mem_req_o  = 1'b1;
                mem_be_o   = 4'hF;
                mem_addr_o = {if_addr_i[XLEN-1:2], 2'b00};
            end
            w_dbg_win: begin
                mem_req_o  = 1'b1;
                mem_be_o   = 4'hF;
                mem_addr_o = {dbg_addr_i[XLEN-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_NONE;
            r_store      <= 1'b0;
            r_cnt        <= '0;
            r_starve     <= '0;
            r_if_rvalid  <= 1'b0;
            r_dm_rvalid  <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_if_rvalid  <= 1'b0;
            r_dm_rvalid  <= 1'b0;
            r_dbg_rvalid <= 1'b0;

            if (w_dbg_win)
                r_starve <= '0;
            else if (w_arb && dbg_req_i && r_starve < STARVE_LIM)
                r_starve <= r_starve + 1'b1;

            unique case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_any) begin
                        r_state <= S_WAIT;
                        r_cnt   <= LAT_INIT;
                        r_store <= w_dm_win & dm_we_i;
                        unique case (1'b1)
                            w_dm_win:  r_owner <= OWN_DM;
                            w_if_win:  r_owner <= OWN_IF;
                            default:   r_owner <= OWN_DBG;
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                        r_owner <= OWN_NONE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_RESP;
                        unique case (r_owner)
                            OWN_IF: begin
                                r_if_rvalid <= 1'b1;
                                r_if_rdata  <= mem_rdata_i;
                            end
                            OWN_DM: begin
                                r_dm_rvalid <= 1'b1;
                                r_dm_rdata  <= r_store ? '0 : mem_rdata_i;
                            end
                            OWN_DBG: begin
                                r_dbg_rvalid <= 1'b1;
                                r_dbg_rdata  <= mem_rdata_i;
                            end
                            default: ;
                        endcase
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_dm;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_perf_if <= '0;
            r_perf_dm <= '0;
        end else begin
            if (if_req_i && !w_if_win && r_perf_if != 32'hFFFF_FFFF)
                r_perf_if <= r_perf_if + 32'd1;
            if (dm_req_i && !w_dm_win && r_perf_dm != 32'hFFFF_FFFF)
                r_perf_dm <= r_perf_dm + 32'd1;
        end
    end

    assign perf_if_wait_o = r_perf_if;
    assign perf_dm_wait_o = r_perf_dm;
`endif

endmodule
